mem_write_arbi_rr: RTL and testbench
====================================

// Module: mem_write_arbi_rr
// PURPOSE
//  Parametrised N-channel write-burst arbiter in front of the DDR write port (mem_clk domain).
//  Grants one channel per burst and forwards its len/addr/data to the memory controller.
//  Grant is work-conserving: the next requester is picked in one cycle, with no per-channel polling.
//  Arbitration mode is selectable at run time: round-robin or fixed priority.
//  A per-burst watchdog aborts a hung burst and reports which channel it was.
// PARAMETERS
//  NCH            8      number of write channels (2..16)
//  MEM_DATA_BITS  32     data width
//  ADDR_BITS      25     burst address width
//  LEN_BITS       10     burst length width
//  TIMEOUT        8000   watchdog limit in cycles per granted burst; 0 disables the watchdog
//  FIN_DLY        2      register stages on wr_burst_finish before it is acted on (0..4)
// PORTS
//  mem_clk                in   1                 clock
//  rst_n                  in   1                 async active-low reset
//  prio_mode              in   1                 0=round-robin, 1=fixed priority (ch0 highest)
//  ch_wr_burst_req        in   NCH               per-channel burst request (level)
//  ch_wr_burst_len        in   NCH*LEN_BITS      packed lengths; ch i at [i*LEN_BITS +: LEN_BITS]
//  ch_wr_burst_addr       in   NCH*ADDR_BITS     packed addresses
//  ch_wr_burst_data       in   NCH*MEM_DATA_BITS packed write data
//  ch_wr_burst_data_req   out  NCH               data strobe, routed to the granted channel only
//  ch_wr_burst_finish     out  NCH               1-cycle pulse at normal burst completion
//  ch_wr_burst_abort      out  NCH               1-cycle pulse when the watchdog kills the burst
//  wr_burst_req           out  1                 request to the memory controller
//  wr_burst_len           out  LEN_BITS          granted length (registered)
//  wr_burst_addr          out  ADDR_BITS         granted address (registered)
//  wr_burst_data_req      in   1                 controller data strobe
//  wr_burst_data          out  MEM_DATA_BITS     muxed data from the granted channel
//  wr_burst_finish        in   1                 controller burst-done pulse
//  grant_id               out  clog2(NCH)        channel currently or most recently granted
//  busy                   out  1                 high in BEGIN/WRITE/END
// BEHAVIOUR
//  Reset: every output is 0. FSM = ARB. RR pointer last = NCH-1, so ch0 wins first.
//    FIN_DLY pipe and watchdog counter are cleared.
//  Eligibility: elig[i] = ch_wr_burst_req[i] && len_i != 0. Zero-length requests are never granted.
//  FSM states: ARB, BEGIN, WRITE, END.
//  ARB:
//    - elig == 0 -> stay in ARB.
//    - Otherwise latch win and go to BEGIN.
//    - win = first set bit of elig scanning last+1 .. last+NCH (mod NCH) when prio_mode=0;
//      lowest set index when prio_mode=1.
//  BEGIN (1 cycle): register len/addr of win. Set wr_burst_req=1 on the next edge. Go to WRITE.
//  wr_burst_req: cleared on the first cycle wr_burst_data_req=1, or on abort.
//  WRITE:
//    - wr_burst_data = granted channel data (combinational); 0 in all other states.
//    - ch_wr_burst_data_req[grant] = wr_burst_data_req; all other bits are 0.
//    - Exit to END when wr_burst_finish, delayed by FIN_DLY registers, is seen.
//  END (1 cycle): ch_wr_burst_finish[grant]=1, last <= grant, go to ARB.
//  Latency:
//    - req sampled in ARB at cycle t gives wr_burst_req=1 at t+2.
//    - Delayed finish at cycle t gives the finish pulse at t+1 and the next grant decision at t+2.
//  Watchdog:
//    - Counter cleared in ARB; increments in BEGIN/WRITE/END.
//    - At count==TIMEOUT-1 and no delayed finish in that cycle: pulse ch_wr_burst_abort[grant],
//      clear wr_burst_req, last <= grant, go to ARB.
//  Simultaneous delayed finish and timeout: finish wins (normal END, no abort).
//  Request drops after grant: the burst completes anyway; no mid-burst pre-emption.
//  prio_mode change: takes effect at the next ARB decision only.
//  Stale finish pulses still inside the FIN_DLY pipe while in ARB/BEGIN are ignored.
//  Reset mid-burst: immediate return to reset values; no finish or abort pulse.
// TESTING
//  1 RR fairness: NCH=4; all req held, len=16, controller finishes each burst.
//    -> grants 0,1,2,3,0; one finish pulse per burst.
//  2 Fixed priority: prio_mode=1; req on ch1 and ch3 held. -> ch1 granted every time, ch3 starves.
//  3 Zero length: ch0 len=0 req=1, ch2 len=8. -> only ch2 granted; ch0 never sees data_req/finish.
//  4 Timeout: TIMEOUT=100; controller never finishes.
//    -> ch_wr_burst_abort[grant] pulses 100 cycles after BEGIN; wr_burst_req=0; next channel granted.
//  5 Race: delayed finish lands on the timeout cycle. -> finish pulse only, no abort.
//  6 Reset: rst_n low mid-WRITE. -> all outputs 0 at once; after release ch0 is granted first.
//    Also check: wr_burst_len/addr equal the granted channel's values; latency req->wr_burst_req = 2 cycles.

Source files
------------

// File: rtl/mem_write_arbi_rr.sv
// mem_write_arbi_rr: N-channel write-burst arbiter in front of the DDR write port.
// Picks one eligible channel per burst (round-robin or fixed priority), forwards
// its len/addr/data to the memory controller and routes the controller strobes
// back to that channel. A per-burst watchdog aborts bursts that never finish.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_ARB   | idle, pick a winner among eligible channels
//   S_BEGIN | latch len/addr of the granted channel, raise wr_burst_req
//   S_WRITE | burst in flight, data/strobe muxed to the granted channel
//   S_END   | one-cycle finish pulse, advance the round-robin pointer
module mem_write_arbi_rr #(
   parameter int NCH           = 8,
   parameter int MEM_DATA_BITS = 32,
   parameter int ADDR_BITS     = 25,
   parameter int LEN_BITS      = 10,
   parameter int TIMEOUT       = 8000,
   parameter int FIN_DLY       = 2
) (
   input  logic                         mem_clk_i,
   input  logic                         rst_n_i,
   input  logic                         prio_mode_i,
   input  logic [NCH-1:0]               ch_wr_burst_req_i,
   input  logic [NCH*LEN_BITS-1:0]      ch_wr_burst_len_i,
   input  logic [NCH*ADDR_BITS-1:0]     ch_wr_burst_addr_i,
   input  logic [NCH*MEM_DATA_BITS-1:0] ch_wr_burst_data_i,
   output logic [NCH-1:0]               ch_wr_burst_data_req_o,
   output logic [NCH-1:0]               ch_wr_burst_finish_o,
   output logic [NCH-1:0]               ch_wr_burst_abort_o,
   output logic                         wr_burst_req_o,
   output logic [LEN_BITS-1:0]          wr_burst_len_o,
   output logic [ADDR_BITS-1:0]         wr_burst_addr_o,
   input  logic                         wr_burst_data_req_i,
   output logic [MEM_DATA_BITS-1:0]     wr_burst_data_o,
   input  logic                         wr_burst_finish_i,
   output logic [$clog2(NCH)-1:0]       grant_id_o,
   output logic                         busy_o
);

   localparam int GW  = $clog2(NCH);
   // Wide enough to hold TIMEOUT itself, so the END cycle after a late finish never wraps.
   localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_ARB   = 2'd0,
      S_BEGIN = 2'd1,
      S_WRITE = 2'd2,
      S_END   = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          last_q, last_d;
   logic [GW-1:0]          grant_q, grant_d;
   logic [LEN_BITS-1:0]    len_q, len_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic                   wr_req_q, wr_req_d;
   logic [NCH-1:0]         abort_q, abort_d;
   logic [WDW-1:0]         wd_cnt_q, wd_cnt_d;

   logic [NCH-1:0]         elig;
   logic [GW-1:0]          win;
   logic                   fin_dly;
   logic                   wd_hit;

   // A channel is eligible only with a live request and a non-zero length.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NCH; i++) begin
         elig[i] = ch_wr_burst_req_i[i] && (ch_wr_burst_len_i[i*LEN_BITS +: LEN_BITS] != '0);
      end
   end

   // Winner select in one pass; scanning backwards lets the first hit in scan order win.
   always_comb begin
      int idx;
      idx = 0;
      win = '0;
      if (prio_mode_i) begin
         for (int i = NCH - 1; i >= 0; i--) begin
            if (elig[i]) win = GW'(i);
         end
      end else begin
         for (int k = NCH; k >= 1; k--) begin
            idx = int'(last_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (elig[idx]) win = GW'(idx);
         end
      end
   end

   // Finish delay line; it always shifts, and only S_WRITE looks at its output,
   // which is what discards stale pulses arriving during ARB/BEGIN.
   generate
      if (FIN_DLY == 0) begin : g_fin_direct
         assign fin_dly = wr_burst_finish_i;
      end else begin : g_fin_pipe
         logic [FIN_DLY-1:0] fin_pipe_q;

         // Shift the controller finish pulse through FIN_DLY stages.
         always_ff @(posedge mem_clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               fin_pipe_q <= '0;
            end else begin
               fin_pipe_q[0] <= wr_burst_finish_i;
               for (int i = 1; i < FIN_DLY; i++) begin
                  fin_pipe_q[i] <= fin_pipe_q[i-1];
               end
            end
         end

         assign fin_dly = fin_pipe_q[FIN_DLY-1];
      end
   endgenerate

   assign wd_hit = (TIMEOUT != 0) && (wd_cnt_q == WDW'(TIMEOUT - 1));

   // Next-state logic: arbitration, burst sequencing and watchdog abort.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      grant_d  = grant_q;
      len_d    = len_q;
      addr_d   = addr_q;
      wr_req_d = wr_req_q;
      abort_d  = '0;
      wd_cnt_d = wd_cnt_q;

      if (state_q != S_ARB && TIMEOUT != 0) begin
         wd_cnt_d = wd_cnt_q + WDW'(1);
      end

      case (state_q)
         S_ARB: begin
            wd_cnt_d = '0;
            if (|elig) begin
               grant_d = win;
               state_d = S_BEGIN;
            end
         end

         S_BEGIN: begin
            for (int i = 0; i < NCH; i++) begin
               if (grant_q == GW'(i)) begin
                  len_d  = ch_wr_burst_len_i[i*LEN_BITS +: LEN_BITS];
                  addr_d = ch_wr_burst_addr_i[i*ADDR_BITS +: ADDR_BITS];
               end
            end
            if (wd_hit) begin
               for (int i = 0; i < NCH; i++) abort_d[i] = (grant_q == GW'(i));
               wr_req_d = 1'b0;
               last_d   = grant_q;
               state_d  = S_ARB;
            end else begin
               wr_req_d = 1'b1;
               state_d  = S_WRITE;
            end
         end

         S_WRITE: begin
            if (wr_burst_data_req_i) wr_req_d = 1'b0;
            // A finish on the timeout cycle takes precedence over the abort.
            if (fin_dly) begin
               wr_req_d = 1'b0;
               state_d  = S_END;
            end else if (wd_hit) begin
               for (int i = 0; i < NCH; i++) abort_d[i] = (grant_q == GW'(i));
               wr_req_d = 1'b0;
               last_d   = grant_q;
               state_d  = S_ARB;
            end
         end

         S_END: begin
            last_d  = grant_q;
            state_d = S_ARB;
         end

         default: begin
            state_d = S_ARB;
         end
      endcase
   end

   // State and datapath registers; the RR pointer resets to NCH-1 so ch0 wins first.
   always_ff @(posedge mem_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_ARB;
         last_q   <= GW'(NCH - 1);
         grant_q  <= '0;
         len_q    <= '0;
         addr_q   <= '0;
         wr_req_q <= 1'b0;
         abort_q  <= '0;
         wd_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         len_q    <= len_d;
         addr_q   <= addr_d;
         wr_req_q <= wr_req_d;
         abort_q  <= abort_d;
         wd_cnt_q <= wd_cnt_d;
      end
   end

   // Route data, strobe and finish to the granted channel only.
   always_comb begin
      ch_wr_burst_data_req_o = '0;
      ch_wr_burst_finish_o   = '0;
      wr_burst_data_o        = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant_q == GW'(i)) begin
            if (state_q == S_WRITE) begin
               ch_wr_burst_data_req_o[i] = wr_burst_data_req_i;
               wr_burst_data_o           = ch_wr_burst_data_i[i*MEM_DATA_BITS +: MEM_DATA_BITS];
            end
            if (state_q == S_END) begin
               ch_wr_burst_finish_o[i] = 1'b1;
            end
         end
      end
   end

   assign ch_wr_burst_abort_o = abort_q;
   assign wr_burst_req_o      = wr_req_q;
   assign wr_burst_len_o      = len_q;
   assign wr_burst_addr_o     = addr_q;
   assign grant_id_o          = grant_q;
   assign busy_o              = (state_q != S_ARB);

endmodule

// File: tb/tb_mem_write_arbi_rr.sv
// Directed bench for mem_write_arbi_rr (4 channels, 100-cycle watchdog, 2-stage finish delay).
module tb_mem_write_arbi_rr;

   localparam int NCH = 4;
   localparam int DB  = 32;
   localparam int AB  = 25;
   localparam int LB  = 10;
   localparam int TO  = 100;
   localparam int FD  = 2;
   localparam int GW  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              prio = 1'b0;
   logic [NCH-1:0]    req = '0;
   logic [NCH*LB-1:0] len_bus = '0;
   logic [NCH*AB-1:0] addr_bus = '0;
   logic [NCH*DB-1:0] data_bus = '0;
   logic              data_req = 1'b0;
   logic              finish = 1'b0;

   logic [NCH-1:0]    ch_data_req, ch_finish, ch_abort;
   logic              wr_burst_req, busy;
   logic [LB-1:0]     wr_burst_len;
   logic [AB-1:0]     wr_burst_addr;
   logic [DB-1:0]     wr_burst_data;
   logic [GW-1:0]     grant_id;

   int n_vec = 0;
   int n_bad = 0;

   mem_write_arbi_rr #(
      .NCH(NCH), .MEM_DATA_BITS(DB), .ADDR_BITS(AB), .LEN_BITS(LB),
      .TIMEOUT(TO), .FIN_DLY(FD)
   ) dut (
      .mem_clk_i              (clk),
      .rst_n_i                (rst_n),
      .prio_mode_i            (prio),
      .ch_wr_burst_req_i      (req),
      .ch_wr_burst_len_i      (len_bus),
      .ch_wr_burst_addr_i     (addr_bus),
      .ch_wr_burst_data_i     (data_bus),
      .ch_wr_burst_data_req_o (ch_data_req),
      .ch_wr_burst_finish_o   (ch_finish),
      .ch_wr_burst_abort_o    (ch_abort),
      .wr_burst_req_o         (wr_burst_req),
      .wr_burst_len_o         (wr_burst_len),
      .wr_burst_addr_o        (wr_burst_addr),
      .wr_burst_data_req_i    (data_req),
      .wr_burst_data_o        (wr_burst_data),
      .wr_burst_finish_i      (finish),
      .grant_id_o             (grant_id),
      .busy_o                 (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AB-1:0] addr_of(input int ch);
      return AB'(32'h000A_B000 + 32'(ch) * 32'h10);
   endfunction

   function automatic logic [DB-1:0] data_of(input int ch);
      return 32'hD0D0_0000 + 32'(ch) * 32'h1111;
   endfunction

   function automatic logic [63:0] bit_of(input int ch);
      return 64'(1) << ch;
   endfunction

   task automatic set_ch(input int ch, input logic r, input logic [LB-1:0] l);
      req[ch]                 = r;
      len_bus[ch*LB +: LB]    = l;
      addr_bus[ch*AB +: AB]   = addr_of(ch);
      data_bus[ch*DB +: DB]   = data_of(ch);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (!wr_burst_req && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_req"}, 64'(wr_burst_req), 64'd1);
   endtask

   // Full normal burst on the expected channel; returns in the END (finish pulse) cycle.
   task automatic do_burst(input string tag, input int ch, input logic [LB-1:0] l);
      int n;
      wait_req(tag);
      check({tag, "_grant"}, 64'(grant_id), 64'(ch));
      check({tag, "_len"},   64'(wr_burst_len), 64'(l));
      check({tag, "_addr"},  64'(wr_burst_addr), 64'(addr_of(ch)));
      data_req = 1'b1;
      #1;
      check({tag, "_dreq"},  64'(ch_data_req), bit_of(ch));
      check({tag, "_data"},  64'(wr_burst_data), 64'(data_of(ch)));
      tick();
      data_req = 1'b0;
      check({tag, "_reqclr"}, 64'(wr_burst_req), 64'd0);
      finish = 1'b1;
      tick();
      finish = 1'b0;
      n = 0;
      while (ch_finish == '0 && ch_abort == '0 && n < 10) begin
         tick();
         n++;
      end
      check({tag, "_fin"},   64'(ch_finish), bit_of(ch));
      check({tag, "_noabt"}, 64'(ch_abort), 64'd0);
   endtask

   initial begin
      int n;

      // Reset values
      tick();
      tick();
      check("rst_req",   64'(wr_burst_req), 64'd0);
      check("rst_busy",  64'(busy), 64'd0);
      check("rst_grant", 64'(grant_id), 64'd0);
      check("rst_len",   64'(wr_burst_len), 64'd0);
      check("rst_data",  64'(wr_burst_data), 64'd0);
      check("rst_chout", 64'({ch_data_req, ch_finish, ch_abort}), 64'd0);

      // 1: round-robin fairness with all channels requesting
      for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, 10'd16);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) do_burst("rr", k % NCH, 10'd16);

      // 2: fixed priority, ch1 always beats ch3
      prio = 1'b1;
      set_ch(0, 1'b0, 10'd0);
      set_ch(2, 1'b0, 10'd0);
      set_ch(1, 1'b1, 10'd8);
      set_ch(3, 1'b1, 10'd8);
      for (int k = 0; k < 3; k++) do_burst("prio", 1, 10'd8);

      // 3: zero-length request on ch0 is never granted
      prio = 1'b0;
      set_ch(1, 1'b0, 10'd0);
      set_ch(3, 1'b0, 10'd0);
      set_ch(0, 1'b1, 10'd0);
      set_ch(2, 1'b1, 10'd8);
      for (int k = 0; k < 2; k++) do_burst("zlen", 2, 10'd8);

      // 4: watchdog abort on ch1, then ch2 is granted next
      set_ch(0, 1'b0, 10'd0);
      set_ch(1, 1'b1, 10'd12);
      set_ch(2, 1'b1, 10'd12);
      wait_req("to");
      check("to_grant", 64'(grant_id), 64'd1);
      n = 0;
      while (ch_abort == '0 && n < 150) begin
         tick();
         n++;
      end
      check("to_cycles", 64'(n), 64'(TO - 1));
      check("to_abort",  64'(ch_abort), bit_of(1));
      check("to_reqclr", 64'(wr_burst_req), 64'd0);
      check("to_nofin",  64'(ch_finish), 64'd0);
      check("to_busy",   64'(busy), 64'd0);
      set_ch(1, 1'b0, 10'd0);
      do_burst("to_next", 2, 10'd12);
      set_ch(2, 1'b0, 10'd0);

      // 5: delayed finish lands exactly on the timeout cycle
      set_ch(3, 1'b1, 10'd20);
      wait_req("race");
      check("race_grant", 64'(grant_id), 64'd3);
      data_req = 1'b1;
      tick();
      data_req = 1'b0;
      repeat (TO - 5) tick();
      finish = 1'b1;
      tick();
      finish = 1'b0;
      tick();
      tick();
      set_ch(3, 1'b0, 10'd0);
      check("race_fin",   64'(ch_finish), bit_of(3));
      check("race_noabt", 64'(ch_abort), 64'd0);
      tick();
      check("race_noabt2", 64'(ch_abort), 64'd0);
      check("race_idle",   64'(busy), 64'd0);

      // 6: reset mid-WRITE, then ch0 wins first with 2-cycle latency
      set_ch(2, 1'b1, 10'd8);
      wait_req("mid");
      data_req = 1'b1;
      #1;
      check("mid_dreq", 64'(ch_data_req), bit_of(2));
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_req",   64'(wr_burst_req), 64'd0);
      check("mrst_busy",  64'(busy), 64'd0);
      check("mrst_grant", 64'(grant_id), 64'd0);
      check("mrst_la",    64'({wr_burst_len, wr_burst_addr}), 64'd0);
      check("mrst_data",  64'(wr_burst_data), 64'd0);
      check("mrst_chout", 64'({ch_data_req, ch_finish, ch_abort}), 64'd0);
      data_req = 1'b0;
      for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, 10'd16);
      tick();
      rst_n = 1'b1;
      tick();
      check("lat_busy",  64'(busy), 64'd1);
      check("lat_req1",  64'(wr_burst_req), 64'd0);
      check("lat_grant", 64'(grant_id), 64'd0);
      tick();
      check("lat_req2",  64'(wr_burst_req), 64'd1);
      do_burst("post0", 0, 10'd16);
      do_burst("post1", 1, 10'd16);
      for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, 10'd0);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
